data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp.sv | 188 ++++++++++++++++++
 tb/tb_data_sram_resp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM with byte enables; WAIT_CYC extra stall cycles per access.
// Latency: access on the edge after WAIT_CYC stall cycles; rdata/resp_valid one cycle later.
// Backpressure: stallreq holds the requester while an access is pending (optional DSRAM_ALIGN_CHK_EN adds addr_err).
module data_sram_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    output logic        resp_valid
`ifdef DSRAM_ALIGN_CHK_EN
    ,
    output logic        addr_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    // Counter preload so that BUSY with cnt counting down to 0 yields exactly WAIT_CYC stall cycles
    // (the IDLE request cycle itself is the first stall cycle).
    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Request captured at acceptance; the pipeline keeps the bus stable, but the
    // access itself is performed from this copy so late bus changes cannot leak in.
    logic [3:0]        lat_wen;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;

    // The access actually performed on this edge (live bus when there are no wait states).
    logic              acc_go;
    logic [3:0]        acc_wen;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              acc_legal;

    logic [31:0] mem [0:DEPTH-1];

    // Address bits outside the word index are intentionally ignored (aliasing allowed).
    logic unused_bits;

`ifdef DSRAM_ALIGN_CHK_EN
    logic [1:0] lat_lo;
    logic [1:0] acc_lo;

    // Byte/half/word lane patterns only; halves and words must be naturally aligned.
    function automatic logic wen_legal(input logic [3:0] w, input logic [1:0] lo);
        logic ok;
        case (w)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            4'b0011, 4'b1100:                             ok = (lo[0] == 1'b0);
            4'b1111:                                      ok = (lo == 2'b00);
            default:                                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign unused_bits = ^data_sram_addr[31:ADDR_W+2];
    assign acc_legal   = wen_legal(acc_wen, acc_lo);
`else
    assign unused_bits = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
    assign acc_legal   = 1'b1;
`endif

    // State register: FSM state and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, return to IDLE on the access edge.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (data_sram_en && (WAIT_CYC != 0)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Output logic: stall while a request is waiting; release in the final BUSY cycle.
    always_comb begin
        stallreq = 1'b0;
        if (WAIT_CYC != 0) begin
            case (state)
                IDLE:    stallreq = data_sram_en;
                BUSY:    stallreq = (cnt != 4'd0);
                default: stallreq = 1'b0;
            endcase
        end
    end

    // Capture the request when it is accepted.
    always_ff @(posedge clk) begin
        if (state == IDLE && data_sram_en) begin
            lat_wen   <= data_sram_wen;
            lat_idx   <= data_sram_addr[ADDR_W+1:2];
            lat_wdata <= data_sram_wdata;
`ifdef DSRAM_ALIGN_CHK_EN
            lat_lo    <= data_sram_addr[1:0];
`endif
        end
    end

    // Select the access for this edge; reset always wins over a pending or new access.
    always_comb begin
        if (WAIT_CYC == 0) begin
            acc_go    = data_sram_en && !rst;
            acc_wen   = data_sram_wen;
            acc_idx   = data_sram_addr[ADDR_W+1:2];
            acc_wdata = data_sram_wdata;
`ifdef DSRAM_ALIGN_CHK_EN
            acc_lo    = data_sram_addr[1:0];
`endif
        end else begin
            acc_go    = (state == BUSY) && (cnt == 4'd0) && !rst;
            acc_wen   = lat_wen;
            acc_idx   = lat_idx;
            acc_wdata = lat_wdata;
`ifdef DSRAM_ALIGN_CHK_EN
            acc_lo    = lat_lo;
`endif
        end
    end

    // Array write: only enabled byte lanes; contents survive reset.
    always_ff @(posedge clk) begin
        if (acc_go && (acc_wen != 4'b0000) && acc_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response registers: read data held until the next read, one-cycle response pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= 32'h0;
            resp_valid      <= 1'b0;
`ifdef DSRAM_ALIGN_CHK_EN
            addr_err        <= 1'b0;
`endif
        end else begin
            resp_valid <= acc_go;
            if (acc_go && (acc_wen == 4'b0000)) begin
                data_sram_rdata <= mem[acc_idx];
            end
`ifdef DSRAM_ALIGN_CHK_EN
            addr_err <= acc_go && !acc_legal;
`endif
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: four instances with WAIT_CYC 0..3 against a transaction-level model.
// Latency: each request is expected to see exactly WAIT_CYC stall cycles, response one cycle after release.
// Backpressure: requests are held on the bus while stallreq is high, as the pipeline would.
module tb_data_sram_resp;

    localparam int ND     = 4;
    localparam int ADDR_W = 10;
    localparam int WIN    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [ND];
    logic        en    [ND];
    logic [3:0]  wen   [ND];
    logic [31:0] addr  [ND];
    logic [31:0] wdata [ND];
    logic [31:0] rdata [ND];
    logic        stall [ND];
    logic        rv    [ND];
`ifdef DSRAM_ALIGN_CHK_EN
    logic        aerr  [ND];
`endif

    for (genvar g = 0; g < ND; g++) begin : g_dut
        data_sram_resp #(
            .ADDR_W   (ADDR_W),
            .WAIT_CYC (g)
        ) u_dut (
            .clk             (clk),
            .rst             (rst[g]),
            .data_sram_en    (en[g]),
            .data_sram_wen   (wen[g]),
            .data_sram_addr  (addr[g]),
            .data_sram_wdata (wdata[g]),
            .data_sram_rdata (rdata[g]),
            .stallreq        (stall[g]),
            .resp_valid      (rv[g])
`ifdef DSRAM_ALIGN_CHK_EN
            ,
            .addr_err        (aerr[g])
`endif
        );
    end

    // Reference model: memory window contents and the last read value per instance.
    logic [31:0] mdl     [ND][WIN];
    logic [31:0] last_rd [ND];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic model_legal(input logic [3:0] w, input logic [1:0] lo);
        if (w == 4'b0000 || $countones(w) == 1) return 1'b1;
        if (w == 4'b0011 || w == 4'b1100)       return lo[0] == 1'b0;
        if (w == 4'b1111)                       return lo == 2'b00;
        return 1'b0;
    endfunction

    // Random address in the modelled window, with random aliasing bits above the index.
    function automatic logic [31:0] mk_addr(input int w, input int lo);
        return ($urandom & 32'hFFFF_F000) | (32'(w) << 2) | 32'(lo);
    endfunction

    // One request as the pipeline issues it; called and returns at a falling edge.
    task automatic access(input int d, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
        int   stalls;
        int   idx;
        logic legal;
        idx      = int'(a[5:2]);
        en[d]    = 1'b1;
        wen[d]   = w;
        addr[d]  = a;
        wdata[d] = wd;
        #1;
        stalls = 0;
        while (stall[d] !== 1'b0 && stalls < 40) begin
            @(negedge clk);
            stalls++;
        end
        chk($sformatf("stall_cycles d%0d", d), 32'(stalls), 32'(d));
        legal = 1'b1;
`ifdef DSRAM_ALIGN_CHK_EN
        legal = model_legal(w, a[1:0]);
`endif
        if (w == 4'b0000) begin
            last_rd[d] = mdl[d][idx];
        end else if (legal) begin
            for (int i = 0; i < 4; i++)
                if (w[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
        end
        @(negedge clk);
        chk($sformatf("resp_valid d%0d", d), 32'(rv[d]), 32'd1);
        chk($sformatf("rdata d%0d wen=%b a=%h", d, w, a), rdata[d], last_rd[d]);
`ifdef DSRAM_ALIGN_CHK_EN
        chk($sformatf("addr_err d%0d wen=%b a=%h", d, w, a), 32'(aerr[d]), 32'(!legal));
`endif
        en[d] = 1'b0;
    endtask

    task automatic idle(input int d, input int n);
        en[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle resp_valid d%0d", d), 32'(rv[d]), 32'd0);
            chk($sformatf("idle stallreq d%0d", d), 32'(stall[d]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        logic [3:0]  w;

        for (int d = 0; d < ND; d++) begin
            rst[d]     = 1'b1;
            en[d]      = 1'b0;
            wen[d]     = 4'b0000;
            addr[d]    = 32'h0;
            wdata[d]   = 32'h0;
            last_rd[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("reset rdata d%0d", d), rdata[d], 32'h0);
            chk($sformatf("reset stallreq d%0d", d), 32'(stall[d]), 32'd0);
            chk($sformatf("reset resp_valid d%0d", d), 32'(rv[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Fill the modelled window of every instance with known words.
        for (int d = 0; d < ND; d++)
            for (int i = 0; i < WIN; i++)
                access(d, 4'b1111, 32'(i) << 2, $urandom);
        idle(0, 1);

        // No wait states: full-word write then read.
        access(0, 4'b1111, 32'h10, 32'hDEADBEEF);
        access(0, 4'b0000, 32'h10, 32'h0);
        chk("wc0 readback", rdata[0], 32'hDEADBEEF);
        idle(0, 2);

        // Two wait states: byte-lane merge.
        access(2, 4'b1111, 32'h20, 32'h11223344);
        access(2, 4'b0010, 32'h20, 32'h0000AA00);
        access(2, 4'b0000, 32'h20, 32'h0);
        chk("wc2 lane merge", rdata[2], 32'h1122AA44);
        idle(2, 2);

        // One wait state: back-to-back write then read of the same word.
        access(1, 4'b1111, 32'h34, 32'hCAFEF00D);
        access(1, 4'b0000, 32'h34, 32'h0);
        chk("wc1 back-to-back", rdata[1], 32'hCAFEF00D);
        idle(1, 2);

        // Three wait states: reset during the second stall cycle discards the write.
        a        = 32'h1C;
        old      = mdl[3][7];
        en[3]    = 1'b1;
        wen[3]   = 4'b1111;
        addr[3]  = a;
        wdata[3] = ~old;
        @(negedge clk);
        rst[3] = 1'b1;
        en[3]  = 1'b0;
        @(negedge clk);
        chk("busy reset stallreq", 32'(stall[3]), 32'd0);
        chk("busy reset rdata", rdata[3], 32'h0);
        chk("busy reset resp_valid", 32'(rv[3]), 32'd0);
        rst[3]     = 1'b0;
        last_rd[3] = 32'h0;
        idle(3, 2);
        access(3, 4'b0000, a, 32'h0);
        chk("busy reset old content", rdata[3], old);
        idle(3, 1);

`ifdef DSRAM_ALIGN_CHK_EN
        // Misaligned word write is rejected; aligned halfword write is accepted.
        old = mdl[0][8];
        access(0, 4'b1111, 32'h22, 32'h55555555);
        access(0, 4'b0000, 32'h20, 32'h0);
        chk("align word unchanged", rdata[0], old);
        access(0, 4'b0011, 32'h24, 32'h0000BEEF);
        access(0, 4'b0000, 32'h24, 32'h0);
        chk("align half low lanes", {16'h0, rdata[0][15:0]}, 32'h0000BEEF);
        idle(0, 1);
`endif

        // Randomised traffic on every instance.
        for (int d = 0; d < ND; d++) begin
            for (int n = 0; n < 60; n++) begin
                w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                access(d, w, mk_addr($urandom_range(0, WIN - 1), $urandom_range(0, 3)), $urandom);
                if ($urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
            end
            idle(d, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
